// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial line of the UART transmitter.
// The master side supplies frames and the slave side is the transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] Tx_Data;
  logic                 Tx_Start;
  logic                 BIST_Mode;
  logic                 Tx_Serial;
  logic                 Tx_Busy;
  logic                 Tx_Ack;
  logic                 Tx_Done;

  modport master (
    output Tx_Data, Tx_Start, BIST_Mode,
    input  Tx_Serial, Tx_Busy, Tx_Ack, Tx_Done
  );

  modport slave (
    input  Tx_Data, Tx_Start, BIST_Mode,
    output Tx_Serial, Tx_Busy, Tx_Ack, Tx_Done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Every output is a register; the frame is fixed once Tx_Data is latched.
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input logic      Clk,
  input logic      Rst,
  uart_tx_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT * 2);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      bus.Tx_Serial <= 1'b1;
      bus.Tx_Busy   <= 1'b0;
      bus.Tx_Ack    <= 1'b0;
      bus.Tx_Done   <= 1'b0;
    end else begin
      bus.Tx_Ack  <= 1'b0;
      bus.Tx_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Tx_Start && !bus.BIST_Mode) begin
            state         <= START;
            shreg         <= bus.Tx_Data;
            // Parity is taken from the payload at acceptance, before shifting starts.
            par_bit       <= parity_of(bus.Tx_Data);
            bit_cnt       <= '0;
            bit_idx       <= '0;
            bus.Tx_Serial <= 1'b0;
            bus.Tx_Busy   <= 1'b1;
            bus.Tx_Ack    <= 1'b1;
          end
        end
        START: begin
          if (bit_cnt == BIT_LAST) begin
            state         <= DATA;
            bit_cnt       <= '0;
            bus.Tx_Serial <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              if (PARITY_EN != 0) begin
                state         <= PARITY;
                bus.Tx_Serial <= par_bit;
              end else begin
                state         <= STOP;
                bus.Tx_Serial <= 1'b1;
              end
            end else begin
              // Line carries shreg[0]; the next bit is shreg[1] before the shift lands.
              bit_idx       <= bit_idx + IDX_W'(1);
              shreg         <= shreg >> 1;
              bus.Tx_Serial <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (bit_cnt == BIT_LAST) begin
            state         <= STOP;
            bit_cnt       <= '0;
            bus.Tx_Serial <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_cnt == STOP_LAST) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            bus.Tx_Serial <= 1'b1;
            bus.Tx_Busy   <= 1'b0;
            bus.Tx_Done   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame shape, parity, back-to-back, BIST and reset.
// Expected frames are queued when a request is driven and popped when the line is captured.
module tb_uart_tx;
  localparam int CPB = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] tx_data;
  logic [2:0] start;
  logic       bist;
  int         sel;
  logic       m_ser, m_busy, m_ack, m_done;
  int         n_checks = 0;
  int         n_fail   = 0;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } exp_t;
  exp_t exp_q[$];

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();

  assign if0.Tx_Data = tx_data;
  assign if1.Tx_Data = tx_data;
  assign if2.Tx_Data = tx_data;
  assign if0.Tx_Start = start[0];
  assign if1.Tx_Start = start[1];
  assign if2.Tx_Start = start[2];
  assign if0.BIST_Mode = bist;
  assign if1.BIST_Mode = bist;
  assign if2.BIST_Mode = bist;

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut0 (.Clk(Clk), .Rst(Rst), .bus(if0.slave));
  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut1 (.Clk(Clk), .Rst(Rst), .bus(if1.slave));
  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    dut2 (.Clk(Clk), .Rst(Rst), .bus(if2.slave));

  always #5 Clk = ~Clk;

  always_comb begin
    m_ser  = if0.Tx_Serial;
    m_busy = if0.Tx_Busy;
    m_ack  = if0.Tx_Ack;
    m_done = if0.Tx_Done;
    case (sel)
      1: begin m_ser = if1.Tx_Serial; m_busy = if1.Tx_Busy; m_ack = if1.Tx_Ack; m_done = if1.Tx_Done; end
      2: begin m_ser = if2.Tx_Serial; m_busy = if2.Tx_Busy; m_ack = if2.Tx_Ack; m_done = if2.Tx_Done; end
      default: ;
    endcase
  end

  // Reference frame: start 0, data LSB first, optional parity, one stop bit.
  function automatic exp_t make_exp(input logic [7:0] d, input int pen, input int odd);
    exp_t e;
    logic p;
    int   idx;
    e.bits = '0;
    p = (odd != 0);
    for (int i = 0; i < 8; i++) begin
      e.bits[1+i] = d[i];
      p = p ^ d[i];
    end
    idx = 9;
    if (pen != 0) begin
      e.bits[idx] = p;
      idx++;
    end
    e.bits[idx] = 1'b1;
    e.len = idx + 1;
    return e;
  endfunction

  task automatic send(input int s, input logic [7:0] d, input int pen, input int odd);
    tx_data  = d;
    start[s] = 1'b1;
    exp_q.push_back(make_exp(d, pen, odd));
  endtask

  // Waits for the acceptance pulse, then records one value per bit period up to the done cycle.
  task automatic capture(input int len, output logic [15:0] got, output bit stable,
                         output int waited, output int done_at, output int acks,
                         output bit busy_ok, output bit idle_at_done);
    int total;
    total = len * CPB;
    got = '0; stable = 1'b1; done_at = -1; acks = 0; busy_ok = 1'b1; idle_at_done = 1'b0; waited = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge Clk);
      if (m_ack === 1'b1) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) return;
    for (int k = 0; k <= total; k++) begin
      if (k > 0) @(negedge Clk);
      if (m_ack === 1'b1) acks++;
      if (m_done === 1'b1 && done_at < 0) done_at = k;
      if (k < total) begin
        if (k % CPB == 0) got[k/CPB] = m_ser;
        else if (m_ser !== got[k/CPB]) stable = 1'b0;
        if (m_busy !== 1'b1) busy_ok = 1'b0;
      end else begin
        idle_at_done = (m_ser === 1'b1) && (m_busy === 1'b0);
      end
    end
  endtask

  task automatic test_reset();
    sel = 0; Rst = 1'b1; start = 3'b001; tx_data = 8'hA5; bist = 1'b0;
    repeat (3) @(negedge Clk);
    n_checks++; if (m_ser !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b expected 1", m_ser); end
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", m_busy); end
    n_checks++; if (m_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", m_ack); end
    n_checks++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", m_done); end
    Rst = 1'b0; start = 3'b000;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    logic [7:0] pats [3] = '{8'h55, 8'h00, 8'hFF};
    logic [15:0] got; bit st, bo, id; int w, da, ac; exp_t e;
    sel = 0;
    foreach (pats[p]) begin
      send(0, pats[p], 0, 0);
      fork
        capture(10, got, st, w, da, ac, bo, id);
        begin @(negedge Clk); start[0] = 1'b0; end
      join
      e = exp_q.pop_front();
      n_checks++; if (w !== 1) begin n_fail++; $display("FAIL basic_ack_latency[%0h]: got %0d expected 1", pats[p], w); end
      n_checks++; if (got !== e.bits) begin n_fail++; $display("FAIL basic_bits[%0h]: got %b expected %b", pats[p], got, e.bits); end
      n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL basic_bit_width[%0h]: got %b expected 1", pats[p], st); end
      n_checks++; if (da !== 40) begin n_fail++; $display("FAIL basic_frame_len[%0h]: got %0d expected 40", pats[p], da); end
      n_checks++; if (ac !== 1) begin n_fail++; $display("FAIL basic_ack_count[%0h]: got %0d expected 1", pats[p], ac); end
      n_checks++; if (bo !== 1'b1 || id !== 1'b1) begin n_fail++; $display("FAIL basic_busy[%0h]: got %b%b expected 11", pats[p], bo, id); end
      @(negedge Clk);
      n_checks++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width[%0h]: got %b expected 0", pats[p], m_done); end
    end
  endtask

  task automatic test_parity();
    logic [15:0] got; bit st, bo, id; int w, da, ac; exp_t e;
    for (int s = 1; s <= 2; s++) begin
      sel = s;
      send(s, 8'h01, 1, s - 1);
      fork
        capture(11, got, st, w, da, ac, bo, id);
        begin @(negedge Clk); start[s] = 1'b0; end
      join
      e = exp_q.pop_front();
      n_checks++; if (got !== e.bits) begin n_fail++; $display("FAIL parity_bits[odd=%0d]: got %b expected %b", s - 1, got, e.bits); end
      n_checks++; if (got[9] !== (s == 1)) begin n_fail++; $display("FAIL parity_bit[odd=%0d]: got %b expected %b", s - 1, got[9], s == 1); end
      n_checks++; if (da !== 44) begin n_fail++; $display("FAIL parity_frame_len[odd=%0d]: got %0d expected 44", s - 1, da); end
      @(negedge Clk);
    end
    sel = 0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] g1, g2; bit st1, st2, bo1, bo2, id1, id2; int w1, w2, da1, da2, ac1, ac2; exp_t e1, e2;
    sel = 0;
    send(0, 8'hA5, 0, 0);
    exp_q.push_back(make_exp(8'h3C, 0, 0));
    fork
      capture(10, g1, st1, w1, da1, ac1, bo1, id1);
      begin @(negedge Clk); tx_data = 8'h3C; end
    join
    fork
      capture(10, g2, st2, w2, da2, ac2, bo2, id2);
      begin
        for (int i = 0; i < 300; i++) begin
          @(negedge Clk);
          if (m_ack === 1'b1) break;
        end
        start[0] = 1'b0;
      end
    join
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    n_checks++; if (g1 !== e1.bits) begin n_fail++; $display("FAIL b2b_frame1: got %b expected %b", g1, e1.bits); end
    n_checks++; if (g2 !== e2.bits) begin n_fail++; $display("FAIL b2b_frame2: got %b expected %b", g2, e2.bits); end
    n_checks++; if (id1 !== 1'b1 || w2 !== 1) begin n_fail++; $display("FAIL b2b_idle_gap: got idle=%b wait=%0d expected idle=1 wait=1", id1, w2); end
    n_checks++; if (ac1 + ac2 !== 2) begin n_fail++; $display("FAIL b2b_acks: got %0d expected 2", ac1 + ac2); end
    n_checks++; if (da1 !== 40 || da2 !== 40) begin n_fail++; $display("FAIL b2b_dones: got %0d,%0d expected 40,40", da1, da2); end
    repeat (3) @(negedge Clk);
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_third: got busy %b expected 0", m_busy); end
  endtask

  task automatic test_midframe();
    logic [15:0] got; bit st, bo, id, quiet; int w, da, ac; exp_t e;
    sel = 0;
    send(0, 8'h5A, 0, 0);
    fork
      capture(10, got, st, w, da, ac, bo, id);
      begin
        @(negedge Clk); start[0] = 1'b0;
        repeat (11) @(negedge Clk);
        start[0] = 1'b1; tx_data = 8'hFF; bist = 1'b1;
        repeat (4) @(negedge Clk);
        start[0] = 1'b0; bist = 1'b0;
      end
    join
    e = exp_q.pop_front();
    n_checks++; if (got !== e.bits) begin n_fail++; $display("FAIL mid_frame_bits: got %b expected %b", got, e.bits); end
    n_checks++; if (ac !== 1) begin n_fail++; $display("FAIL mid_extra_ack: got %0d expected 1", ac); end
    n_checks++; if (da !== 40) begin n_fail++; $display("FAIL mid_frame_len: got %0d expected 40", da); end
    quiet = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      if (m_busy !== 1'b0 || m_ack !== 1'b0) quiet = 1'b0;
    end
    n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL mid_no_queued: got %b expected 1", quiet); end
  endtask

  task automatic test_bist();
    bit ser_ok, busy_ok, ack_ok;
    sel = 0; ser_ok = 1'b1; busy_ok = 1'b1; ack_ok = 1'b1;
    tx_data = 8'h00; bist = 1'b1; start[0] = 1'b1;
    repeat (20) begin
      @(negedge Clk);
      if (m_ser !== 1'b1) ser_ok = 1'b0;
      if (m_busy !== 1'b0) busy_ok = 1'b0;
      if (m_ack !== 1'b0) ack_ok = 1'b0;
    end
    start[0] = 1'b0; bist = 1'b0;
    @(negedge Clk);
    n_checks++; if (ser_ok !== 1'b1) begin n_fail++; $display("FAIL bist_serial: got %b expected 1", ser_ok); end
    n_checks++; if (busy_ok !== 1'b1 || m_busy !== 1'b0) begin n_fail++; $display("FAIL bist_busy: got %b expected 1", busy_ok); end
    n_checks++; if (ack_ok !== 1'b1) begin n_fail++; $display("FAIL bist_ack: got %b expected 1", ack_ok); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] got; bit st, bo, id, no_done; int w, da, ac; exp_t e;
    sel = 0; w = -1;
    tx_data = 8'h33; start[0] = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge Clk);
      if (m_ack === 1'b1) begin w = i; break; end
    end
    start[0] = 1'b0;
    n_checks++; if (w !== 1) begin n_fail++; $display("FAIL rstmid_accept: got %0d expected 1", w); end
    repeat (13) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    n_checks++; if (m_ser !== 1'b1) begin n_fail++; $display("FAIL rstmid_serial: got %b expected 1", m_ser); end
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", m_busy); end
    no_done = 1'b1;
    repeat (50) begin
      @(negedge Clk);
      if (m_done !== 1'b0 || m_ser !== 1'b1) no_done = 1'b0;
    end
    n_checks++; if (no_done !== 1'b1) begin n_fail++; $display("FAIL rstmid_no_done: got %b expected 1", no_done); end
    send(0, 8'h33, 0, 0);
    fork
      capture(10, got, st, w, da, ac, bo, id);
      begin @(negedge Clk); start[0] = 1'b0; end
    join
    e = exp_q.pop_front();
    n_checks++; if (got !== e.bits) begin n_fail++; $display("FAIL rstmid_new_bits: got %b expected %b", got, e.bits); end
    n_checks++; if (da !== 40) begin n_fail++; $display("FAIL rstmid_new_len: got %0d expected 40", da); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_midframe();
    test_bist();
    test_reset_midframe();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (5..9).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning Clk cycles per serial bit (minimum 2).
REQ-003 The block SHALL have parameter PARITY_EN, default 0, meaning 1 inserts a parity bit after the data bits.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, meaning 0 is even parity and 1 is odd parity.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning number of stop bits (1 or 2).
REQ-006 The block SHALL have port Clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-007 The block SHALL have port Rst, input, 1 bit, synchronous active-high reset.
REQ-008 The block SHALL have port Tx_Data, input, DATA_BITS bits, the payload to send.
REQ-009 The block SHALL have port Tx_Start, input, 1 bit, the transmit request level, sampled only in IDLE.
REQ-010 The block SHALL have port BIST_Mode, input, 1 bit; while high, Tx_Start is ignored.
REQ-011 The block SHALL have port Tx_Serial, output, 1 bit, the serial line (idle = 1).
REQ-012 The block SHALL have port Tx_Busy, output, 1 bit, high from frame acceptance until frame completion.
REQ-013 The block SHALL have port Tx_Ack, output, 1 bit, a one-cycle pulse when Tx_Data is latched.
REQ-014 The block SHALL have port Tx_Done, output, 1 bit, a one-cycle pulse when the last stop bit completes.

Function
REQ-015 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-016 FSM states SHALL be: IDLE, START, DATA, PARITY, STOP.
REQ-017 Acceptance SHALL occur at the edge where state is IDLE, Tx_Start=1 and BIST_Mode=0. After that edge: state=START, Tx_Data latched into a shift register, Tx_Serial=0, Tx_Busy=1, Tx_Ack=1 for exactly one cycle.
REQ-018 Each bit SHALL drive Tx_Serial for exactly CLKS_PER_BIT cycles, timed by a bit counter that clears on every bit boundary.
REQ-019 The START state SHALL be followed by DATA. DATA SHALL shift out DATA_BITS bits, LSB first, with a bit index from 0 to DATA_BITS-1.
REQ-020 After the last data bit, the FSM SHALL go to PARITY if PARITY_EN=1; otherwise it SHALL go to STOP.
REQ-021 The parity bit SHALL be the XOR of the latched data bits, inverted when PARITY_ODD=1.
REQ-022 STOP SHALL drive 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-023 At the edge ending STOP: state=IDLE, Tx_Busy=0, Tx_Serial=1, Tx_Done=1 for one cycle.
REQ-024 Tx_Start sampled high during the Tx_Done cycle SHALL be accepted at the next edge, giving exactly one idle-high cycle between frames.
REQ-025 Tx_Start and BIST_Mode SHALL be ignored while Tx_Busy=1; requests are not queued.
REQ-026 Tx_Data changes after acceptance SHALL NOT affect the frame in flight.
REQ-027 BIST_Mode asserted mid-frame SHALL NOT abort the frame.
REQ-028 Total frame time, from acceptance edge to Tx_Done edge, SHALL be (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-029 The bit counter SHALL be sized to clog2(CLKS_PER_BIT*2) bits and SHALL never wrap within a bit.

Reset
REQ-030 Rst=1 at an edge SHALL force: state=IDLE, Tx_Serial=1, Tx_Busy=0, Tx_Ack=0, Tx_Done=0, counters=0, shift register=0.
REQ-031 Rst SHALL take priority over Tx_Start in the same cycle.
REQ-032 Rst mid-frame SHALL abort the frame without a Tx_Done pulse; Tx_Serial SHALL be 1 from the next cycle.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-033 Scenario 1: PARITY_EN=0, send 0x55. Tx_Serial SHALL be 0,1,0,1,0,1,0,1,0,1, each bit for 4 cycles. Tx_Done SHALL occur 40 cycles after the acceptance edge, and Tx_Ack SHALL be a single one-cycle pulse.
REQ-034 Scenario 2: PARITY_EN=1 and PARITY_ODD=0, send 0x01. The parity bit SHALL be 1. With PARITY_ODD=1, send 0x01. The parity bit SHALL be 0. Frame length SHALL be 44 cycles.
REQ-035 Scenario 3: hold Tx_Start=1 continuously and send 0xA5 then 0x3C. There SHALL be exactly one idle-high cycle between frames. There SHALL be two Tx_Ack pulses and two Tx_Done pulses.
REQ-036 Scenario 4: pulse Tx_Start during DATA and change Tx_Data to 0xFF mid-frame. The frame in flight SHALL be unchanged, and there SHALL be no extra Tx_Ack.
REQ-037 Scenario 5: BIST_Mode=1 with Tx_Start=1 for 20 cycles. Tx_Serial SHALL stay 1, Tx_Busy SHALL stay 0, and there SHALL be no Tx_Ack.
REQ-038 Scenario 6: assert Rst for 1 cycle in the 3rd data bit. On the next cycle Tx_Serial SHALL be 1 and Tx_Busy SHALL be 0. There SHALL be no Tx_Done. A new Tx_Start SHALL then produce a full frame.
